fetch_mem_unit: RTL and testbench

//  Datapath front end of the multicycle processor, directly upstream of ControlUnit.

---
 rtl/fetch_mem_unit.sv | 135 +++++++++++++
 tb/tb_fetch_mem_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_mem_unit.sv
// Multicycle datapath front end: PC, IR, MDR and a ready/request unified memory port.
// Optional access timeout with sticky mem_err, enabled by defining FETCH_TIMEOUT_EN.
module fetch_mem_unit #(
    parameter int unsigned     XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int unsigned     TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCwrite,
    input  logic            branch,
    input  logic            zero,
    input  logic [1:0]      PCsrc,
    input  logic            IorD,
    input  logic            IRWrite,
    input  logic            memread,
    input  logic            memwrite,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr,
    output logic [5:0]      opcode,
    output logic [XLEN-1:0] mdr,
    output logic            mem_stall,
    output logic            mem_err
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic            lat_we;
    logic            acc;
    logic            busy;
    logic            timeout_hit;
    logic            capture;
    logic            pc_en;
    logic [XLEN-1:0] pc_next;

    assign acc    = memread | memwrite;
    assign busy   = (state == BUSY);
    assign opcode = instr[31:26];

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tcnt;

    assign timeout_hit = busy & ~mem_ready & (tcnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Port outputs are gated by rst so an in-flight request drops the moment reset asserts.
    always_comb begin
        mem_req   = rst & (busy | acc);
        mem_we    = rst & (busy ? lat_we : memwrite);
        mem_addr  = busy ? lat_addr : ((rst & IorD) ? alu_out : pc);
        mem_wdata = busy ? lat_wdata : wdata;
        mem_stall = mem_req & ~mem_ready & ~timeout_hit;
        capture   = mem_req & mem_ready & ~mem_we;
        pc_en     = (PCwrite | (branch & zero)) & ~mem_stall;
    end

    always_comb begin
        pc_next = pc;
        unique case (PCsrc)
            2'b00: pc_next = alu_result;
            2'b01: pc_next = alu_out;
            2'b10: pc_next = {pc[XLEN-1:28], instr[25:0], 2'b00};
            2'b11: pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_addr  <= RESET_PC;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            pc        <= RESET_PC;
            instr     <= '0;
            mdr       <= '0;
            mem_err   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tcnt      <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc && !mem_ready) begin
                        state     <= BUSY;
                        lat_addr  <= mem_addr;
                        lat_we    <= memwrite;
                        lat_wdata <= wdata;
`ifdef FETCH_TIMEOUT_EN
                        tcnt      <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        state <= IDLE;
                    end else if (timeout_hit) begin
                        state   <= IDLE;
                        mem_err <= 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
            endcase

            if (capture) begin
                if (IRWrite) instr <= mem_rdata[31:0];
                else         mdr   <= mem_rdata;
            end

            if (pc_en) pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed bench for fetch_mem_unit: register results go through a scoreboard queue,
// port/handshake values are checked directly with immediate assertions.
module tb_fetch_mem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCwrite, branch, zero, IorD, IRWrite, memread, memwrite, mem_ready;
    logic [1:0]  PCsrc;
    logic [31:0] alu_result, alu_out, wdata, mem_rdata;
    logic        mem_req, mem_we, mem_stall, mem_err;
    logic [31:0] mem_addr, mem_wdata, pc, instr, mdr;
    logic [5:0]  opcode;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    typedef struct {
        string       tag;
        int unsigned sel;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    fetch_mem_unit #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .PCwrite(PCwrite), .branch(branch), .zero(zero),
        .PCsrc(PCsrc), .IorD(IorD), .IRWrite(IRWrite), .memread(memread),
        .memwrite(memwrite), .alu_result(alu_result), .alu_out(alu_out),
        .wdata(wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .pc(pc), .instr(instr), .opcode(opcode),
        .mdr(mdr), .mem_stall(mem_stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic push(input string tag, input int unsigned sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int unsigned sel);
        case (sel)
            0:       return pc;
            1:       return instr;
            2:       return mdr;
            3:       return {26'd0, opcode};
            default: return {31'd0, mem_err};
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        PCwrite = 0; branch = 0; zero = 0; PCsrc = 2'b11; IorD = 0; IRWrite = 0;
        memread = 0; memwrite = 0; mem_ready = 0;
    endtask

    initial begin
        idle_inputs();
        alu_result = '0; alu_out = '0; wdata = '0; mem_rdata = '0;
        rst = 0;
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_mdr", mdr, 32'h0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        tick();
        rst = 1;
        tick();

        // zero-wait fetch
        memread = 1; IRWrite = 1; PCwrite = 1; PCsrc = 2'b00; alu_result = 32'h4;
        mem_ready = 1; mem_rdata = 32'h8C220004;
        #1;
        check("f0_req", {31'd0, mem_req}, 32'd1);
        check("f0_we", {31'd0, mem_we}, 32'd0);
        check("f0_addr", mem_addr, 32'h0);
        check("f0_stall", {31'd0, mem_stall}, 32'd0);
        push("f0_instr", 1, 32'h8C220004);
        push("f0_pc", 0, 32'h4);
        push("f0_opcode", 3, 32'h23);
        tick();
        drain();

        // fetch with two wait cycles
        mem_ready = 0; alu_result = 32'h8; mem_rdata = 32'hDEADBEEF;
        #1;
        check("w1_stall", {31'd0, mem_stall}, 32'd1);
        check("w1_addr", mem_addr, 32'h4);
        tick();
        IorD = 1; alu_out = 32'h000DEAD0;
        #1;
        check("w2_stall", {31'd0, mem_stall}, 32'd1);
        check("w2_req", {31'd0, mem_req}, 32'd1);
        check("w2_addr", mem_addr, 32'h4);
        check("w2_pc", pc, 32'h4);
        check("w2_instr", instr, 32'h8C220004);
        tick();
        IorD = 0; mem_ready = 1; mem_rdata = 32'h00430820;
        #1;
        check("w3_stall", {31'd0, mem_stall}, 32'd0);
        push("w3_instr", 1, 32'h00430820);
        push("w3_pc", 0, 32'h8);
        tick();
        drain();

        // data read into MDR
        idle_inputs();
        memread = 1; IorD = 1; alu_out = 32'h100; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        #1;
        check("ld_addr", mem_addr, 32'h100);
        push("ld_mdr", 2, 32'hCAFEF00D);
        push("ld_instr", 1, 32'h00430820);
        push("ld_pc", 0, 32'h8);
        tick();
        drain();

        // store with one wait cycle; write data latched
        idle_inputs();
        memwrite = 1; IorD = 1; alu_out = 32'h200; wdata = 32'h000055AA; mem_rdata = 32'h11111111;
        #1;
        check("st_we", {31'd0, mem_we}, 32'd1);
        check("st_stall", {31'd0, mem_stall}, 32'd1);
        tick();
        wdata = 32'h12345678; alu_out = 32'h300; mem_ready = 1;
        #1;
        check("st_wdata", mem_wdata, 32'h000055AA);
        check("st_addr", mem_addr, 32'h200);
        check("st_we2", {31'd0, mem_we}, 32'd1);
        push("st_mdr", 2, 32'hCAFEF00D);
        push("st_instr", 1, 32'h00430820);
        tick();
        drain();

        // branches
        idle_inputs();
        branch = 1; zero = 1; PCsrc = 2'b01; alu_out = 32'h40;
        push("br_taken", 0, 32'h40);
        tick();
        drain();
        zero = 0; alu_out = 32'h80;
        push("br_not", 0, 32'h40);
        tick();
        drain();

        // load a jump into IR, then jump
        idle_inputs();
        memread = 1; IRWrite = 1; PCwrite = 1; PCsrc = 2'b00; alu_result = 32'h10;
        mem_ready = 1; mem_rdata = 32'h08000010;
        push("j_fetch_pc", 0, 32'h10);
        push("j_fetch_ir", 1, 32'h08000010);
        tick();
        drain();
        idle_inputs();
        PCwrite = 1; PCsrc = 2'b10;
        push("j_pc", 0, 32'h40);
        tick();
        drain();
        PCsrc = 2'b11;
        push("hold_pc", 0, 32'h40);
        tick();
        drain();

`ifdef FETCH_TIMEOUT_EN
        idle_inputs();
        memread = 1; IRWrite = 1; mem_rdata = 32'hFFFFFFFF;
        tick();
        for (int i = 1; i < 16; i++) begin
            check("to_stall", {31'd0, mem_stall}, 32'd1);
            tick();
        end
        check("to_release", {31'd0, mem_stall}, 32'd0);
        check("to_err_pre", {31'd0, mem_err}, 32'd0);
        push("to_err", 4, 32'd1);
        push("to_instr", 1, 32'h08000010);
        tick();
        drain();
`endif

        // reset while an access is pending
        idle_inputs();
        memread = 1; IRWrite = 1; PCwrite = 1; PCsrc = 2'b00; alu_result = 32'h44; IorD = 1;
        alu_out = 32'h500;
        tick();
        #2;
        rst = 0;
        #1;
        check("mr_pc", pc, 32'h0);
        check("mr_instr", instr, 32'h0);
        check("mr_mdr", mdr, 32'h0);
        check("mr_req", {31'd0, mem_req}, 32'd0);
        check("mr_stall", {31'd0, mem_stall}, 32'd0);
        check("mr_err", {31'd0, mem_err}, 32'd0);
        check("mr_addr", mem_addr, 32'h0);
        idle_inputs();
        tick();
        rst = 1;
        tick();
        check("post_req", {31'd0, mem_req}, 32'd0);
        check("post_pc", pc, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
